trick_timer_detect: RTL
=======================

# trick_timer_detect

Parametrised successor to the OPL single-timer detection trick. The block snoops the host register bus in the OPL clock domain and counts status reads after software starts Timer 1 and/or Timer 2. When enough reads have occurred to cover the programmed timer period, it forces that timer's overflow. It sits beside the timer block and drives that block's per-timer force-overflow inputs; unlike the previous version, it handles any preload value and both timers.

## Interface
Parameters:
- NUM_TIMERS, 2, timer channels handled (1 = Timer 1 only; 2 = Timers 1 and 2).
- READS_PER_TICK, 50, host reads counted as one Timer 1 tick (80 µs); Timer 2 ticks count as 4× this.
- IDLE_TIMEOUT_CYCLES, 2^20, clk cycles without a read before an armed channel disarms (only with TRICK_SW_DETECT_TIMEOUT_EN).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  OPL clock; all logic runs on its rising edge.
- reset  in  1  synchronous active-high reset.
- cs_n  in  1  host chip select, active low, asynchronous to clk.
- rd_n  in  1  host read strobe, active low.
- wr_n  in  1  host write strobe, active low.
- address  in  1  0 = register-address write, 1 = data write.
- din  in  REG_FILE_DATA_WIDTH (8)  host write data.
- force_timer_overflow  out  NUM_TIMERS  per-timer forced overflow, level; bit 0 = Timer 1.
- armed  out  NUM_TIMERS  channel currently counting reads; for debug and verification.

## Operation
- Bus front end:
  - Register cs_n/rd_n/wr_n/address/din once (p1), then keep a second stage of the strobes (p2).
  - Write event = (!cs_p1_n & !wr_p1_n) & !wr_p2. Read event is formed the same way from rd.
  - A write event with address=0 latches din into reg_addr.
  - A write event with address=1 produces a one-cycle reg_wr {valid, reg_addr, din}.
- Preload capture: reg_wr to 0x02 sets preload[0]; reg_wr to 0x03 sets preload[1].
- Writing the preload register of an armed channel disarms that channel and clears its force bit.
- reg_wr to 0x04:
  - data[7]=1 (IRQ reset): disarm all channels and clear every force bit; all other bits are ignored.
  - Otherwise channel i (start bit data[i], mask bit data[6-i]):
    - start=1 and mask=0: arm. count←0, force←0, threshold←(256−preload[i])·READS_PER_TICK·(i?4:1).
    - start=0: disarm and clear force.
    - start=1 and mask=1: disarm and clear force.
- Counting:
  - While armed and not yet at threshold, each read event increments count.
  - force_timer_overflow[i] sets on the edge where count reaches threshold; it then holds until disarm, IRQ reset or reset.
  - The counter saturates at threshold.
- Writes to any other register are ignored.
- Width rules:
  - threshold/count width = $clog2(256·4·READS_PER_TICK+1), 16 bits at the default.
  - Threshold multiply is done at arm time, unsigned, no truncation.

## Timing
- Reset values: force_timer_overflow=0, armed=0, count=0, preload=0, reg_addr=0, all pipeline stages idle (strobes high).
- Bus latency:
  - Strobe low before edge n gives p1 at n and a write/read event combinationally in cycle n.
  - reg_wr is valid at edge n+1; arm/disarm takes effect at edge n+2.
- Read-to-force latency: the read event in cycle n increments count at edge n+1. If that reaches threshold, force rises at the same edge n+1.
- Priority: reset > IRQ reset > arm/disarm write > read increment.
  - An arm in the same cycle as a read event wins: count=0.
- Reset mid-count clears everything next edge; no force pulse escapes.
- Holding a strobe low counts one event only; the next event requires a high sample first.

## Configuration
- TRICK_SW_DETECT_TIMEOUT_EN defined:
  - Each armed channel runs an idle counter, cleared by every read event.
  - Reaching IDLE_TIMEOUT_CYCLES disarms the channel; force is left unchanged.
- Undefined: no idle counter is instantiated; a channel stays armed until a write or reset.

## Structure
- opl2_pkg holds:
  - REG_FILE_DATA_WIDTH and opl2_reg_wr_t (reused).
  - New constants TIMER1_REG_ADDR=0x02, TIMER2_REG_ADDR=0x03, TIMER_CTRL_REG_ADDR=0x04.
  - Per-timer tick multiplier constants {1,4}.
- One sub-module, trick_timer_detect_channel: preload, threshold, counter, force and optional timeout for one timer.
  - Instantiated NUM_TIMERS times by generate.
  - The top level owns the bus front end and reg_wr decode.

## Test plan
- 0x02←0xFF, 0x04←0x21, 49 reads: force[0]=0. 50th read: force[0]=1 one edge after the read event; armed[0]=1.
- 0x02←0xFE, arm as above: force[0] rises on read 100, not on read 99; further reads keep count at 100.
- 0x03←0xFF, 0x04←0x42: force[1] rises on read 200; force[0] stays 0.
- Arm Timer 1, 30 reads, 0x04←0x80: force=0, armed=0. 40 more reads: no assertion.
- Arm Timer 1, 25 reads, reset for 1 cycle: all outputs 0. Re-arm: force needs a full 50 reads.
- 0x04←0x41 (start T1 but masked): armed[0]=0; 300 reads give force=0. With TRICK_SW_DETECT_TIMEOUT_EN and IDLE_TIMEOUT_CYCLES=100, arm then idle 100 cycles: armed[0]=0.

Source files
------------

// File: rtl/opl2_pkg.sv
// Shared OPL2 register-file types and timer register constants.
package opl2_pkg;

  localparam int unsigned REG_FILE_DATA_WIDTH = 8;

  typedef struct packed {
    logic                           valid;
    logic [REG_FILE_DATA_WIDTH-1:0] addr;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } opl2_reg_wr_t;

  localparam logic [REG_FILE_DATA_WIDTH-1:0] TIMER1_REG_ADDR     = 8'h02;
  localparam logic [REG_FILE_DATA_WIDTH-1:0] TIMER2_REG_ADDR     = 8'h03;
  localparam logic [REG_FILE_DATA_WIDTH-1:0] TIMER_CTRL_REG_ADDR = 8'h04;

  // Timer 2 ticks are four Timer 1 ticks long.
  localparam int unsigned TIMER1_TICK_MULT = 1;
  localparam int unsigned TIMER2_TICK_MULT = 4;

endpackage

// File: rtl/trick_timer_detect_channel.sv
// One timer channel: preload capture, read-count threshold, force flag and,
// with TRICK_SW_DETECT_TIMEOUT_EN, an idle disarm counter.
module trick_timer_detect_channel
  import opl2_pkg::*;
#(
  parameter int unsigned CHANNEL             = 0,
  parameter int unsigned READS_PER_TICK      = 50,
  parameter int unsigned IDLE_TIMEOUT_CYCLES = 1 << 20,
  parameter int unsigned CNT_W               = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  opl2_reg_wr_t reg_wr,
  input  logic         read_evt,
  output logic         force_ovf,
  output logic         armed
);

  localparam logic [REG_FILE_DATA_WIDTH-1:0] PreloadAddr =
      (CHANNEL == 0) ? TIMER1_REG_ADDR : TIMER2_REG_ADDR;
  localparam int unsigned TickMult = (CHANNEL == 0) ? TIMER1_TICK_MULT : TIMER2_TICK_MULT;
  localparam int unsigned StartBit = CHANNEL;
  localparam int unsigned MaskBit  = 6 - CHANNEL;

  logic [REG_FILE_DATA_WIDTH-1:0] preload_q, preload_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [CNT_W-1:0]               threshold_q, threshold_d;
  logic [CNT_W-1:0]               threshold_calc;
  logic                           armed_q, armed_d;
  logic                           force_q, force_d;
  logic                           ctrl_wr, pre_wr;

  assign ctrl_wr = reg_wr.valid && (reg_wr.addr == TIMER_CTRL_REG_ADDR);
  assign pre_wr  = reg_wr.valid && (reg_wr.addr == PreloadAddr);

  // CNT_W is sized for the largest product, so the cast never drops bits.
  assign threshold_calc =
      CNT_W'((32'd256 - 32'(preload_q)) * READS_PER_TICK * TickMult);

`ifdef TRICK_SW_DETECT_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT_CYCLES + 1);
  logic [IdleW-1:0] idle_q, idle_d;
`else
  logic unused_idle_param;
  assign unused_idle_param = ^IDLE_TIMEOUT_CYCLES;
`endif

  always_comb begin
    preload_d   = preload_q;
    count_d     = count_q;
    threshold_d = threshold_q;
    armed_d     = armed_q;
    force_d     = force_q;
`ifdef TRICK_SW_DETECT_TIMEOUT_EN
    idle_d      = idle_q;
`endif

    if (pre_wr) preload_d = reg_wr.data;

    if (ctrl_wr) begin
      if (!reg_wr.data[7] && reg_wr.data[StartBit] && !reg_wr.data[MaskBit]) begin
        armed_d     = 1'b1;
        count_d     = '0;
        force_d     = 1'b0;
        threshold_d = threshold_calc;
`ifdef TRICK_SW_DETECT_TIMEOUT_EN
        idle_d      = '0;
`endif
      end else begin
        armed_d = 1'b0;
        force_d = 1'b0;
      end
    end else if (pre_wr && armed_q) begin
      armed_d = 1'b0;
      force_d = 1'b0;
    end else if (armed_q) begin
`ifdef TRICK_SW_DETECT_TIMEOUT_EN
      // Timeout leaves force untouched so a late overflow is not lost.
      if (read_evt) begin
        idle_d = '0;
      end else if (idle_q == IdleW'(IDLE_TIMEOUT_CYCLES - 1)) begin
        idle_d  = '0;
        armed_d = 1'b0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
`endif
      if (read_evt && (count_q < threshold_q)) begin
        count_d = count_q + 1'b1;
        if (count_d == threshold_q) force_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      preload_q   <= '0;
      count_q     <= '0;
      threshold_q <= '0;
      armed_q     <= 1'b0;
      force_q     <= 1'b0;
`ifdef TRICK_SW_DETECT_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      preload_q   <= preload_d;
      count_q     <= count_d;
      threshold_q <= threshold_d;
      armed_q     <= armed_d;
      force_q     <= force_d;
`ifdef TRICK_SW_DETECT_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign force_ovf = force_q;
  assign armed     = armed_q;

endmodule

// File: rtl/trick_timer_detect.sv
// Snoops the OPL host bus and forces timer overflow after enough status reads.
// Optional idle disarm is enabled by defining TRICK_SW_DETECT_TIMEOUT_EN.
module trick_timer_detect
  import opl2_pkg::*;
#(
  parameter int unsigned NUM_TIMERS          = 2,
  parameter int unsigned READS_PER_TICK      = 50,
  parameter int unsigned IDLE_TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cs_n,
  input  logic                           rd_n,
  input  logic                           wr_n,
  input  logic                           address,
  input  logic [REG_FILE_DATA_WIDTH-1:0] din,
  output logic [NUM_TIMERS-1:0]          force_timer_overflow,
  output logic [NUM_TIMERS-1:0]          armed
);

  localparam int unsigned CntW = $clog2(256 * 4 * READS_PER_TICK + 1);

  logic                           cs_p1_n_q, rd_p1_n_q, wr_p1_n_q, addr_p1_q;
  logic [REG_FILE_DATA_WIDTH-1:0] din_p1_q;
  logic                           rd_p2_q, wr_p2_q;
  logic [REG_FILE_DATA_WIDTH-1:0] reg_addr_q, reg_addr_d;
  opl2_reg_wr_t                   reg_wr_q, reg_wr_d;
  logic                           rd_act, wr_act, rd_evt, wr_evt;

  // p2 holds last cycle's active level so a held strobe yields one event.
  assign rd_act = !cs_p1_n_q && !rd_p1_n_q;
  assign wr_act = !cs_p1_n_q && !wr_p1_n_q;
  assign rd_evt = rd_act && !rd_p2_q;
  assign wr_evt = wr_act && !wr_p2_q;

  always_comb begin
    reg_addr_d     = reg_addr_q;
    reg_wr_d.valid = wr_evt && addr_p1_q;
    reg_wr_d.addr  = reg_addr_q;
    reg_wr_d.data  = din_p1_q;
    if (wr_evt && !addr_p1_q) reg_addr_d = din_p1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_p1_n_q  <= 1'b1;
      rd_p1_n_q  <= 1'b1;
      wr_p1_n_q  <= 1'b1;
      addr_p1_q  <= 1'b0;
      din_p1_q   <= '0;
      rd_p2_q    <= 1'b0;
      wr_p2_q    <= 1'b0;
      reg_addr_q <= '0;
      reg_wr_q   <= '0;
    end else begin
      cs_p1_n_q  <= cs_n;
      rd_p1_n_q  <= rd_n;
      wr_p1_n_q  <= wr_n;
      addr_p1_q  <= address;
      din_p1_q   <= din;
      rd_p2_q    <= rd_act;
      wr_p2_q    <= wr_act;
      reg_addr_q <= reg_addr_d;
      reg_wr_q   <= reg_wr_d;
    end
  end

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
    trick_timer_detect_channel #(
      .CHANNEL            (i),
      .READS_PER_TICK     (READS_PER_TICK),
      .IDLE_TIMEOUT_CYCLES(IDLE_TIMEOUT_CYCLES),
      .CNT_W              (CntW)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .reg_wr   (reg_wr_q),
      .read_evt (rd_evt),
      .force_ovf(force_timer_overflow[i]),
      .armed    (armed[i])
    );
  end

endmodule
